// File: rtl/store_monitor.sv
// -----------------------------------------------------------------------------
// store_monitor
//
// Purpose:
//    Self-checking monitor for the data-memory write bus of the multicycle
//    processor. A FIFO of expected (address, data) stores is loaded while the
//    monitor is idle. On start, every processor store is compared in order
//    against the FIFO head. The result is reported as pass or fail, and a
//    cycle timeout catches a processor that stops storing. The same check
//    runs in simulation and on the FPGA.
//
// Ports:
//    clk          system clock, all state updates on the rising edge
//    reset        asynchronous active-low reset (0 = reset)
//    exp_valid    push one expected store (IDLE only)
//    exp_adr      expected store address
//    exp_data     expected store data
//    start        IDLE -> RUN (IDLE -> FAIL if the FIFO overflowed)
//    clear        PASS/FAIL -> IDLE, flushes FIFO and results
//    memwrite     processor store strobe
//    dataadr      processor store address
//    writedata    processor store data
//    done         high in PASS or FAIL
//    pass         high in PASS
//    fail         high in FAIL
//    err_code     0 none, 1 data/address mismatch, 2 timeout, 3 FIFO overflow
//    store_count  checked stores accepted so far, saturating at 255
//    fail_adr     dataadr of the offending store, else 0
//    fail_data    writedata of the offending store, else 0
// -----------------------------------------------------------------------------
module store_monitor #(
   parameter int          DEPTH      = 8,
   parameter logic [31:0] IGNORE_ADR = 32'd84,
   parameter int          TIMEOUT    = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exp_valid,
   input  logic [31:0] exp_adr,
   input  logic [31:0] exp_data,
   input  logic        start,
   input  logic        clear,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic [1:0]  err_code,
   output logic [7:0]  store_count,
   output logic [31:0] fail_adr,
   output logic [31:0] fail_data
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISMATCH = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State and registers
   // ---------------------------------------------------------------------------
   state_t        r_state;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [PW:0]   r_count;
   logic          r_ovf;
   logic [CW-1:0] r_cyc;
   logic [7:0]    r_scount;
   logic [1:0]    r_err;
   logic [31:0]   r_fadr;
   logic [31:0]   r_fdata;
   logic          r_done;
   logic          r_pass;
   logic          r_fail;

   // Expected-store storage (contents need no reset; occupancy guards reads)
   logic [31:0]   r_mem_adr  [DEPTH];
   logic [31:0]   r_mem_data [DEPTH];

   // ---------------------------------------------------------------------------
   // Next-state signals
   // ---------------------------------------------------------------------------
   state_t        w_state_next;
   logic          w_push;
   logic          w_pop;
   logic          w_flush;
   logic          w_ovf_next;
   logic [CW-1:0] w_cyc_next;
   logic [7:0]    w_scount_next;
   logic [1:0]    w_err_next;
   logic [31:0]   w_fadr_next;
   logic [31:0]   w_fdata_next;
   logic          w_full;
   logic          w_empty;
   logic          w_check;
   logic          w_match;
   logic [31:0]   w_head_adr;
   logic [31:0]   w_head_data;

   assign w_full      = (r_count == (PW+1)'(DEPTH));
   assign w_empty     = (r_count == '0);
   assign w_head_adr  = r_mem_adr[r_head];
   assign w_head_data = r_mem_data[r_head];
   // Stores to the scratch location are never checked
   assign w_check     = memwrite && (dataadr != IGNORE_ADR);
   assign w_match     = (dataadr == w_head_adr) && (writedata == w_head_data);

   always_comb begin
      w_state_next  = r_state;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_flush       = 1'b0;
      w_ovf_next    = r_ovf;
      w_cyc_next    = r_cyc;
      w_scount_next = r_scount;
      w_err_next    = r_err;
      w_fadr_next   = r_fadr;
      w_fdata_next  = r_fdata;

      case (r_state)
         S_IDLE: begin
            if (exp_valid) begin
               if (!w_full) begin
                  w_push = 1'b1;
               end else begin
                  w_ovf_next = 1'b1;
               end
            end
            // Uses the updated overflow flag so a same-cycle dropped push counts
            if (start) begin
               if (w_ovf_next) begin
                  w_state_next = S_FAIL;
                  w_err_next   = ERR_OVERFLOW;
               end else begin
                  w_state_next = S_RUN;
                  w_cyc_next   = '0;
               end
            end
         end

         S_RUN: begin
            w_cyc_next = r_cyc + 1'b1;
            if (w_check && (w_empty || !w_match)) begin
               w_state_next = S_FAIL;
               w_err_next   = ERR_MISMATCH;
               w_fadr_next  = dataadr;
               w_fdata_next = writedata;
            end else begin
               if (w_check) begin
                  w_pop = 1'b1;
                  if (r_scount != 8'hFF) begin
                     w_scount_next = r_scount + 8'd1;
                  end
               end
               // Emptiness is judged after this cycle's pop, so a final match
               // on the timeout cycle still passes
               if (r_count == (PW+1)'(w_pop)) begin
                  w_state_next = S_PASS;
               end else if (r_cyc == CW'(TIMEOUT - 1)) begin
                  w_state_next = S_FAIL;
                  w_err_next   = ERR_TIMEOUT;
               end
            end
         end

         S_PASS, S_FAIL: begin
            if (clear) begin
               w_state_next  = S_IDLE;
               w_flush       = 1'b1;
               w_ovf_next    = 1'b0;
               w_scount_next = 8'd0;
               w_err_next    = ERR_NONE;
               w_fadr_next   = 32'd0;
               w_fdata_next  = 32'd0;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_cyc    <= '0;
         r_scount <= 8'd0;
         r_err    <= ERR_NONE;
         r_fadr   <= 32'd0;
         r_fdata  <= 32'd0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
         r_fail   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_ovf    <= w_ovf_next;
         r_cyc    <= w_cyc_next;
         r_scount <= w_scount_next;
         r_err    <= w_err_next;
         r_fadr   <= w_fadr_next;
         r_fdata  <= w_fdata_next;
         r_done   <= (w_state_next == S_PASS) || (w_state_next == S_FAIL);
         r_pass   <= (w_state_next == S_PASS);
         r_fail   <= (w_state_next == S_FAIL);
         if (w_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            // Push happens only in IDLE and pop only in RUN, never together
            if (w_push) begin
               r_tail  <= r_tail + 1'b1;
               r_count <= r_count + 1'b1;
            end
            if (w_pop) begin
               r_head  <= r_head + 1'b1;
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_adr[r_tail]  <= exp_adr;
         r_mem_data[r_tail] <= exp_data;
      end
   end

   assign done        = r_done;
   assign pass        = r_pass;
   assign fail        = r_fail;
   assign err_code    = r_err;
   assign store_count = r_scount;
   assign fail_adr    = r_fadr;
   assign fail_data   = r_fdata;

endmodule

// File: tb/tb_store_monitor.sv
// -----------------------------------------------------------------------------
// tb_store_monitor
//
// Purpose:
//    Directed bench for store_monitor. Inputs are driven 1 ns after each
//    rising edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_store_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        exp_valid;
   logic [31:0] exp_adr;
   logic [31:0] exp_data;
   logic        start;
   logic        clear;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic        done;
   logic        pass;
   logic        fail;
   logic [1:0]  err_code;
   logic [7:0]  store_count;
   logic [31:0] fail_adr;
   logic [31:0] fail_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   store_monitor #(.DEPTH(8), .IGNORE_ADR(32'd84), .TIMEOUT(30)) dut (
      .clk         (clk),
      .reset       (reset),
      .exp_valid   (exp_valid),
      .exp_adr     (exp_adr),
      .exp_data    (exp_data),
      .start       (start),
      .clear       (clear),
      .memwrite    (memwrite),
      .dataadr     (dataadr),
      .writedata   (writedata),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .err_code    (err_code),
      .store_count (store_count),
      .fail_adr    (fail_adr),
      .fail_data   (fail_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      exp_valid = 1'b1; exp_adr = a; exp_data = d;
      tick();
      exp_valid = 1'b0;
      $display("push adr=%0d data=%0d", a, d);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      $display("start");
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; dataadr = a; writedata = d;
      tick();
      memwrite = 1'b0;
      $display("store adr=%0d data=%0d -> done=%0d pass=%0d fail=%0d err=%0d cnt=%0d",
               a, d, done, pass, fail, err_code, store_count);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      $display("clear");
   endtask

   initial begin
      reset = 1'b0; exp_valid = 1'b0; exp_adr = '0; exp_data = '0;
      start = 1'b0; clear = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
      tick(); tick();
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err_code), 32'd0);
      check("rst_cnt", 32'(store_count), 32'd0);
      check("rst_fadr", fail_adr, 32'd0);
      reset = 1'b1;
      tick();

      // Single matching store
      push(40, 49);
      do_start();
      check("t1_run_done", 32'(done), 32'd0);
      store(40, 49);
      check("t1_pass", 32'(pass), 32'd1);
      check("t1_done", 32'(done), 32'd1);
      check("t1_cnt", 32'(store_count), 32'd1);
      check("t1_err", 32'(err_code), 32'd0);
      do_clear();
      check("t1_clr_cnt", 32'(store_count), 32'd0);

      // Scratch address ignored
      push(40, 49); push(44, 7);
      do_start();
      store(84, 5);
      store(40, 49);
      check("t2_cnt_mid", 32'(store_count), 32'd1);
      check("t2_done_mid", 32'(done), 32'd0);
      store(44, 7);
      check("t2_pass", 32'(pass), 32'd1);
      check("t2_cnt", 32'(store_count), 32'd2);
      do_clear();

      // Data mismatch, then hold, then clear
      push(40, 49);
      do_start();
      store(40, 48);
      check("t3_fail", 32'(fail), 32'd1);
      check("t3_err", 32'(err_code), 32'd1);
      check("t3_fadr", fail_adr, 32'd40);
      check("t3_fdata", fail_data, 32'd48);
      check("t3_cnt", 32'(store_count), 32'd0);
      store(40, 49);
      check("t3_hold_fdata", fail_data, 32'd48);
      check("t3_hold_fail", 32'(fail), 32'd1);
      do_clear();
      check("t3_clr_done", 32'(done), 32'd0);
      check("t3_clr_fail", 32'(fail), 32'd0);
      check("t3_clr_err", 32'(err_code), 32'd0);
      check("t3_clr_fadr", fail_adr, 32'd0);
      check("t3_clr_fdata", fail_data, 32'd0);

      // Empty FIFO start -> PASS after one cycle (also proves IDLE after clear)
      do_start();
      check("t3b_run_done", 32'(done), 32'd0);
      tick();
      check("t3b_pass", 32'(pass), 32'd1);
      do_clear();

      // Address mismatch
      push(40, 49);
      do_start();
      store(44, 49);
      check("t3c_err", 32'(err_code), 32'd1);
      check("t3c_fadr", fail_adr, 32'd44);
      do_clear();

      // Unexpected store on the first RUN cycle with an empty FIFO
      do_start();
      store(60, 1);
      check("t3d_fail", 32'(fail), 32'd1);
      check("t3d_fadr", fail_adr, 32'd60);
      do_clear();

      // Timeout exactly 30 cycles after RUN entry
      push(40, 49);
      do_start();
      repeat (29) tick();
      check("t4_done_29", 32'(done), 32'd0);
      tick();
      check("t4_fail", 32'(fail), 32'd1);
      check("t4_err", 32'(err_code), 32'd2);
      $display("timeout run -> fail=%0d err=%0d", fail, err_code);
      do_clear();

      // Matching store on the last cycle before timeout
      push(40, 49);
      do_start();
      repeat (29) tick();
      store(40, 49);
      check("t4b_pass", 32'(pass), 32'd1);
      check("t4b_err", 32'(err_code), 32'd0);
      do_clear();

      // Nine pushes overflow the 8-entry FIFO
      for (int i = 0; i < 9; i++) push(32'(100 + 4 * i), 32'(i));
      do_start();
      check("t5_fail", 32'(fail), 32'd1);
      check("t5_err", 32'(err_code), 32'd3);
      do_clear();
      check("t5_clr_err", 32'(err_code), 32'd0);

      // Exactly full FIFO (pointer wrap) checks cleanly
      for (int i = 0; i < 8; i++) push(32'(200 + 4 * i), 32'(1000 + i));
      do_start();
      for (int i = 0; i < 8; i++) store(32'(200 + 4 * i), 32'(1000 + i));
      check("t5b_pass", 32'(pass), 32'd1);
      check("t5b_cnt", 32'(store_count), 32'd8);
      do_clear();

      // Asynchronous reset mid-RUN
      push(40, 49); push(44, 7);
      do_start();
      store(40, 49);
      check("t6_cnt_pre", 32'(store_count), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t6_async_cnt", 32'(store_count), 32'd0);
      check("t6_async_done", 32'(done), 32'd0);
      $display("async reset -> cnt=%0d done=%0d", store_count, done);
      tick();
      reset = 1'b1;
      tick();
      push(40, 49);
      do_start();
      store(40, 49);
      check("t6_pass", 32'(pass), 32'd1);
      check("t6_cnt", 32'(store_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Synthesizable checker that sits directly downstream of the multicycle processor top.
- Consumes its data-memory write bus (memwrite, dataadr, writedata) and compares every store against a preloaded FIFO of expected (address, data) pairs.
- Raises pass/fail with a timeout, replacing ad-hoc end-of-test checks so the same check runs in simulation and on FPGA.

Parameters:
DEPTH, 8, expected-store FIFO entries (power of 2)
IGNORE_ADR, 32'd84, store address excluded from checking (scratch location)
TIMEOUT, 30, max clk cycles in RUN before declaring timeout

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
exp_valid  input  1  push one expected store (accepted only in IDLE)
exp_adr  input  32  expected store address
exp_data  input  32  expected store data
start  input  1  IDLE->RUN
clear  input  1  PASS/FAIL->IDLE, empties FIFO
memwrite  input  1  processor store strobe
dataadr  input  32  processor store address
writedata  input  32  processor store data
done  output  1  high in PASS or FAIL
pass  output  1  high in PASS
fail  output  1  high in FAIL
err_code  output  2  0 none, 1 data/addr mismatch, 2 timeout, 3 FIFO overflow
store_count  output  8  checked stores accepted so far, saturates at 255
fail_adr  output  32  dataadr of mismatching store, else 0
fail_data  output  32  writedata of mismatching store, else 0

Behaviour:
- Reset (reset=0, async): state=IDLE, FIFO empty, overflow flag=0, cycle counter=0, all outputs 0.
- States: IDLE, RUN, PASS, FAIL. done/pass/fail/err_code are registered and valid the cycle after state entry.
- IDLE:
  - exp_valid=1 with FIFO not full: push, count+1.
  - exp_valid=1 with FIFO full: drop the entry, set sticky overflow.
  - memwrite ignored.
  - start=1: if overflow, go to FAIL with err_code=3; else go to RUN, cycle counter=0.
  - exp_valid and start in the same cycle: the push occurs first, then RUN.
- RUN:
  - Cycle counter increments each cycle. exp_valid and start ignored.
  - memwrite=0, or memwrite=1 with dataadr==IGNORE_ADR: no check.
  - Other memwrite=1 with FIFO non-empty:
    - Exact 32-bit match of both fields against head: pop, store_count+1.
    - Otherwise: FAIL, err_code=1, fail_adr/fail_data capture the bus values.
  - Other memwrite=1 with FIFO empty: unexpected store, FAIL, err_code=1, capture bus values.
  - FIFO empty (including after a pop): go to PASS next cycle. Starting RUN with an empty FIFO gives PASS after one cycle.
  - Cycle counter reaching TIMEOUT-1 while FIFO still non-empty after this cycle's check: FAIL, err_code=2.
  - A final matching pop on the timeout cycle yields PASS, not timeout.
- PASS/FAIL:
  - Hold all outputs; memwrite ignored.
  - clear=1: go to IDLE, flush FIFO, zero store_count, overflow, err_code, fail_adr and fail_data.
  - clear in IDLE/RUN: no effect.
- FIFO: circular buffer with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy counter of log2(DEPTH)+1 bits.
- store_count saturates at 8'hFF.
- Reset asserted mid-RUN: immediate return to reset values; any stores in flight are discarded.

Test Plan:
- Load (40,49), start, drive memwrite with dataadr=40, writedata=49 -> store_count=1, pass=1, done=1, err_code=0 one cycle after the store.
- Load (40,49),(44,7); stores (84,5),(40,49),(44,7) -> the 84 store is ignored, store_count=2, PASS.
- Load (40,49); store (40,48) -> fail=1, err_code=1, fail_adr=40, fail_data=48, store_count=0; clear -> all outputs 0, state IDLE.
- Load (40,49), start, no memwrite -> fail=1, err_code=2 exactly TIMEOUT=30 cycles after RUN entry. Repeat with the matching store on cycle 29 -> PASS.
- Push 9 entries with DEPTH=8, then start -> FAIL, err_code=3. Also start with an empty FIFO -> PASS after one cycle.
- Assert reset=0 mid-RUN after one match -> store_count=0 and done=0 immediately (asynchronously). Release, reload and rerun -> PASS.
